// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM MAC lane: fixed-point format, default widths
// and the feeder's sequencing states.
package lstm_pkg;

  localparam int LSTM_DATA_WIDTH   = 12;
  localparam int LSTM_OUTPUT_WIDTH = 12;
  localparam int FRAC_BITS         = 6;
  localparam int INT_BITS          = 5;
  localparam int LSTM_MAX_LEN      = 64;
  localparam int LSTM_PE_LATENCY   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    HOLD
  } feeder_state_t;

endpackage

// File: rtl/pe_result_slot.sv
// One-entry register slice holding the PE's dot-product result until the
// consumer takes it over a valid/ready handshake.
module pe_result_slot #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  // A load always wins; the feeder never loads while a result is still held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_stream_feeder.sv
// Transmit-side sequencer for one LSTM MAC lane: clears the accumulator, streams
// (data, weight) pairs with zero bubbles, waits out the PE pipeline, captures the result.
module pe_stream_feeder
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH   = LSTM_DATA_WIDTH,
  parameter int OUTPUT_WIDTH = LSTM_OUTPUT_WIDTH,
  parameter int MAX_LEN      = LSTM_MAX_LEN,
  parameter int PE_LATENCY   = LSTM_PE_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic [DATA_WIDTH-1:0]          s_weight,
  input  logic                           s_last,
  output logic [DATA_WIDTH-1:0]          pe_data,
  output logic [DATA_WIDTH-1:0]          pe_weight,
  output logic                           pe_clear,
  input  logic [OUTPUT_WIDTH-1:0]        pe_result,
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic [OUTPUT_WIDTH-1:0]        r_data,
  output logic [$clog2(MAX_LEN+1)-1:0]   elem_count,
  output logic                           len_err
);

  localparam int CW  = $clog2(MAX_LEN + 1);
  localparam int DRW = $clog2(PE_LATENCY + 1);
  localparam logic [CW-1:0]  LAST_IDX   = CW'(MAX_LEN - 1);
  localparam logic [DRW-1:0] DRAIN_LOAD = DRW'(PE_LATENCY);

  feeder_state_t  state;
  logic [DRW-1:0] drain_cnt;
  logic           handshake;
  logic           at_max;
  logic           is_last;
  logic           capture;

  assign s_ready   = (state == STREAM);
  assign handshake = s_valid && s_ready;
  assign at_max    = (elem_count == LAST_IDX);
  assign is_last   = s_last || at_max;
  assign capture   = (state == DRAIN) && (drain_cnt == '0);

  // pe_data/pe_weight default to zero every edge so idle cycles feed a zero
  // product; only a STREAM handshake loads a real element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pe_data    <= '0;
      pe_weight  <= '0;
      pe_clear   <= 1'b0;
      elem_count <= '0;
      drain_cnt  <= '0;
      len_err    <= 1'b0;
    end else begin
      pe_data   <= '0;
      pe_weight <= '0;
      pe_clear  <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid) begin
            state    <= CLEAR;
            pe_clear <= 1'b1;
          end
        end
        CLEAR: begin
          state <= STREAM;
        end
        STREAM: begin
          if (handshake) begin
            pe_data    <= s_data;
            pe_weight  <= s_weight;
            elem_count <= elem_count + CW'(1);
            if (at_max && !s_last) begin
              len_err <= 1'b1;
            end
            if (is_last) begin
              drain_cnt <= DRAIN_LOAD;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= HOLD;
          end else begin
            drain_cnt <= drain_cnt - DRW'(1);
          end
        end
        HOLD: begin
          if (r_valid && r_ready) begin
            elem_count <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  pe_result_slot #(
    .WIDTH (OUTPUT_WIDTH)
  ) u_result_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (pe_result),
    .valid     (r_valid),
    .ready     (r_ready),
    .data      (r_data)
  );

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Bench for pe_stream_feeder with a behavioural 4-stage MAC lane attached and a
// scoreboard of expected dot products built from the driven elements.
module tb_pe_stream_feeder;
  import lstm_pkg::*;

  localparam int DW   = 12;
  localparam int OW   = 12;
  localparam int MAXL = 64;
  localparam int LAT  = 4;
  localparam int CW   = $clog2(MAXL + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [DW-1:0] s_weight;
  logic          s_last;
  logic [DW-1:0] pe_data;
  logic [DW-1:0] pe_weight;
  logic          pe_clear;
  logic [OW-1:0] pe_result;
  logic          r_valid;
  logic          r_ready;
  logic [OW-1:0] r_data;
  logic [CW-1:0] elem_count;
  logic          len_err;

  typedef struct {
    logic [OW-1:0] res;
    int            count;
    int            nonzero;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   exp_len_err = 1'b0;
  bit   gap_check = 1'b0;

  always #5 clk = ~clk;

  pe_stream_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_weight   (s_weight),
    .s_last     (s_last),
    .pe_data    (pe_data),
    .pe_weight  (pe_weight),
    .pe_clear   (pe_clear),
    .pe_result  (pe_result),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_data     (r_data),
    .elem_count (elem_count),
    .len_err    (len_err)
  );

  function automatic logic [OW-1:0] qmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed(a) * $signed(b);
    return p[FRAC_BITS +: OW];
  endfunction

  // PE lane model: accumulate one edge after the operands register, then three
  // more pipeline stages so output_reg trails pe_data by LAT edges.
  logic [OW-1:0] acc, pipe1, pipe2, pe_out;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; pipe1 <= '0; pipe2 <= '0; pe_out <= '0;
    end else begin
      acc    <= pe_clear ? '0 : acc + qmul(pe_data, pe_weight);
      pipe1  <= acc;
      pipe2  <= pipe1;
      pe_out <= pipe2;
    end
  end
  assign pe_result = pe_out;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
  endtask

  // Monitor samples one time unit before each rising edge.
  int            cyc = 0;
  bit            prev_hs = 1'b0;
  bit            prev_rv = 1'b0;
  logic [DW-1:0] prev_d, prev_w;
  int            last_hs_cyc = 0;
  int            clear_cyc = -100;
  int            res_hs_cyc = -100;
  int            clear_cnt = 0;
  int            vec_hs = 0;
  int            nz_cnt = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    #4;
    cyc++;
    if (rst) begin
      prev_hs = 1'b0; prev_rv = 1'b0;
      clear_cnt = 0; vec_hs = 0; nz_cnt = 0;
    end else begin
      checkOutput("pe_data", pe_data, prev_hs ? prev_d : '0);
      checkOutput("pe_weight", pe_weight, prev_hs ? prev_w : '0);
      if (pe_data != '0) nz_cnt++;
      if (pe_clear) begin
        clear_cnt++;
        clear_cyc = cyc;
      end
      if (r_valid) begin
        checkOutput("s_ready_in_hold", s_ready, 0);
        if (sb_q.size() > 0) checkOutput("r_data", r_data, sb_q[0].res);
        else checkOutput("unexpected_r_valid", r_valid, 0);
      end
      if (r_valid && !prev_rv) checkOutput("capture_latency", cyc - 1 - last_hs_cyc, LAT + 1);
      if (r_valid && r_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("elem_count", elem_count, e.count);
        checkOutput("nonzero_cycles", nz_cnt, e.nonzero);
        checkOutput("clear_pulses", clear_cnt, 1);
        checkOutput("len_err", len_err, exp_len_err);
        clear_cnt = 0; nz_cnt = 0; vec_hs = 0;
        res_hs_cyc = cyc;
      end
      prev_hs = s_valid && s_ready;
      if (prev_hs) begin
        prev_d = s_data;
        prev_w = s_weight;
        if (vec_hs == 0) begin
          checkOutput("clear_to_first_hs", cyc - clear_cyc, 1);
          if (gap_check) checkOutput("result_to_next_hs", cyc - res_hs_cyc, 3);
        end
        vec_hs++;
        last_hs_cyc = cyc;
      end
      prev_rv = r_valid;
    end
  end

  task automatic sendElement(input logic [DW-1:0] d, input logic [DW-1:0] w, input logic last, output bit ok);
    int guard;
    s_valid = 1'b1; s_data = d; s_weight = w; s_last = last;
    guard = 0;
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = s_ready;
    if (!ok) checkOutput("accept_timeout", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Pushes the expected result, then streams n elements d, d+step, ... times w.
  task automatic applyStimulus(input int n, input logic [DW-1:0] d, input logic [DW-1:0] w,
                               input logic [DW-1:0] step, input bit gaps, input bit with_last);
    exp_t          e;
    bit            ok;
    logic [DW-1:0] cur;
    e.res = '0; e.count = n; e.nonzero = n;
    for (int i = 0; i < n; i++) e.res += qmul(d + DW'(i) * step, w);
    if (!with_last && n == MAXL) exp_len_err = 1'b1;
    sb_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      cur = d + DW'(i) * step;
      sendElement(cur, w, with_last && (i == n - 1), ok);
      if (!ok) return;
      if (gaps && i != n - 1) @(negedge clk);
    end
  endtask

  task automatic waitResult();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      checkOutput("result_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string phase);
    checkOutput({phase, "_s_ready"}, s_ready, 0);
    checkOutput({phase, "_pe_data"}, pe_data, 0);
    checkOutput({phase, "_pe_weight"}, pe_weight, 0);
    checkOutput({phase, "_pe_clear"}, pe_clear, 0);
    checkOutput({phase, "_r_valid"}, r_valid, 0);
    checkOutput({phase, "_r_data"}, r_data, 0);
    checkOutput({phase, "_elem_count"}, elem_count, 0);
    checkOutput({phase, "_len_err"}, len_err, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit ok;
    int guard;
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_weight = '0; s_last = 1'b0; r_ready = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic 4-element vector");
    applyStimulus(4, 12'h040, 12'h020, 12'h000, 1'b0, 1'b1);
    waitResult();

    $display("[TB] same vector with bubbles");
    applyStimulus(4, 12'h040, 12'h020, 12'h000, 1'b1, 1'b1);
    waitResult();

    $display("[TB] varying data, negative weight");
    applyStimulus(5, 12'h010, 12'hFC0, 12'h008, 1'b0, 1'b1);
    waitResult();

    $display("[TB] truncation at MAX_LEN");
    applyStimulus(MAXL, 12'h040, 12'h001, 12'h000, 1'b0, 1'b0);
    waitResult();

    $display("[TB] result backpressure");
    r_ready = 1'b0;
    applyStimulus(3, 12'h020, 12'h040, 12'h000, 1'b0, 1'b1);
    guard = 0;
    while (!r_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!r_valid) checkOutput("backpressure_timeout", r_valid, 1);
    repeat (10) @(negedge clk);
    r_ready = 1'b1;
    gap_check = 1'b1;
    applyStimulus(4, 12'h040, 12'h020, 12'h000, 1'b0, 1'b1);
    waitResult();
    gap_check = 1'b0;

    $display("[TB] reset mid-stream");
    sendElement(12'h040, 12'h020, 1'b0, ok);
    sendElement(12'h040, 12'h020, 1'b0, ok);
    #2 rst = 1'b1;
    #1 checkAllZero("midreset");
    exp_len_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(4, 12'h040, 12'h020, 12'h000, 1'b0, 1'b1);
    waitResult();

    $display("[TB] single-element vector");
    applyStimulus(1, 12'h7FF, 12'h040, 12'h000, 1'b0, 1'b1);
    waitResult();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
- Transmit-side sequencer for one LSTM MAC processing-element lane.
- Accepts a stream of (data, weight) element pairs over valid/ready and drives them, registered, onto the PE's data/weight inputs.
- Inserts zero bubbles whenever no element is available, and issues a one-cycle accumulator clear before each vector.
- After the PE pipeline drains, captures the PE's accumulated result and presents it on a valid/ready result port.

Parameters:
- DATA_WIDTH, 12, width of data/weight elements (Q5.6 signed fixed point)
- OUTPUT_WIDTH, 12, width of PE accumulated result
- MAX_LEN, 64, maximum elements per vector
- PE_LATENCY, 4, edges from a registered pe_data/pe_weight update to the corresponding output_reg update in the PE

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_valid  in  1  input element valid
- s_ready  out  1  feeder can accept an element
- s_data  in  DATA_WIDTH  input activation element
- s_weight  in  DATA_WIDTH  input weight element
- s_last  in  1  marks final element of the vector
- pe_data  out  DATA_WIDTH  registered data to PE data_in
- pe_weight  out  DATA_WIDTH  registered weight to PE weight_in
- pe_clear  out  1  one-cycle accumulator clear to PE lane
- pe_result  in  OUTPUT_WIDTH  PE output_reg
- r_valid  out  1  result valid
- r_ready  in  1  result consumer ready
- r_data  out  OUTPUT_WIDTH  captured dot-product result
- elem_count  out  clog2(MAX_LEN+1)  elements accepted in current vector
- len_err  out  1  sticky: vector truncated at MAX_LEN without s_last

Behaviour:
- Clock and reset: rst asynchronous, active-high; clock clk, all state on posedge clk.
- Reset values: all outputs 0; state IDLE; counters 0; len_err 0.
- IDLE:
  - s_ready=0.
  - Moves to CLEAR the first cycle s_valid=1; that element is not consumed.
- CLEAR:
  - pe_clear=1 for exactly one cycle; pe_data/pe_weight=0; s_ready=0.
  - Next state is STREAM.
- STREAM:
  - s_ready=1.
  - On handshake (s_valid&s_ready): pe_data<=s_data, pe_weight<=s_weight, elem_count++.
  - Cycles without a handshake: pe_data/pe_weight<=0 (zero product, accumulator unchanged).
  - Last element: handshake with s_last=1, or the handshake that makes elem_count==MAX_LEN.
  - If the MAX_LEN-th element arrives without s_last, set len_err (sticky until rst) and treat that element as last.
  - On the last element: load drain_cnt<=PE_LATENCY and go to DRAIN.
- DRAIN:
  - s_ready=0; pe_data/pe_weight<=0.
  - drain_cnt decrements each edge.
  - On the edge where drain_cnt==0: r_data<=pe_result, r_valid<=1, go to HOLD.
  - Result capture edge is therefore e+PE_LATENCY+1, where e is the edge of the last handshake (e+5 at the default).
- HOLD:
  - r_valid=1 and r_data stable until r_ready.
  - On r_valid&r_ready: r_valid<=0, elem_count<=0, go to IDLE.
  - Back-to-back vectors: 3-cycle minimum gap (HOLD→IDLE→CLEAR→STREAM).
- pe_clear never asserts outside CLEAR; pe_data/pe_weight are 0 in every state except STREAM handshakes.
- s_valid while not in STREAM: ignored, no element lost (ready low).
- r_ready while r_valid=0: ignored.
- rst mid-vector: immediate return to IDLE, all outputs 0; the partial vector is discarded.
- No arithmetic in the block; widths are passed through unchanged.

Decomposition:
- Shared package lstm_pkg:
  - DATA_WIDTH/OUTPUT_WIDTH defaults, FRAC_BITS=6, INT_BITS=5.
  - State enum {IDLE, CLEAR, STREAM, DRAIN, HOLD}.
  - PE_LATENCY default.
- No sub-module is required.
- The result capture plus handshake is written as the natural leaf pe_result_slot (1-entry register slice), instantiated once.

Test Plan:
- Basic vector: 4 elements (data 1.0=0x040, weight 0.5=0x020, s_valid continuous, s_last on 4th).
  - pe_clear one pulse before the first element.
  - pe_data sequence 0x040 ×4.
  - r_valid rises 5 edges after the last handshake.
  - r_data=pe_result sampled then; with the PE model attached, r_data=0x080 (2.0).
- Bubbles: same vector with s_valid toggling 1/0.
  - pe_data/pe_weight read 0 on idle cycles.
  - elem_count ends at 4; r_data identical to the basic case.
- Truncation: 64 elements with no s_last.
  - The 64th element is treated as last; len_err=1 and stays set through subsequent vectors until rst.
- Result backpressure: r_ready held 0 for 10 cycles after r_valid.
  - r_data stable and s_ready=0 throughout.
  - After r_ready=1: next vector accepted, pe_clear pulses again, and the first STREAM handshake occurs 3 cycles after the result handshake.
- Reset mid-stream: assert rst after 2 of 4 elements.
  - All outputs 0 asynchronously, state IDLE.
  - A following full vector completes with the correct count (4) and no stale r_valid.
- Single-element vector: s_last on first element (data 0x7FF, weight 0x040).
  - Exactly one nonzero pe_data cycle; capture at edge e+5; elem_count=1.
